mfp_ahb_led_sequencer: RTL and testbench
========================================

Name: mfp_ahb_led_sequencer

Overview:
- AHB-Lite slave that owns the board LED bank and schedules what drives it.
- In manual mode the LEDs show a CPU-written value. In sequence mode the block steps autonomously through a programmable pattern table at a programmable rate, looping or one-shot.
- Sits on the AHB decoder alongside the GPIO slave, and replaces direct CPU ownership of IO_LED.

Parameters:
- N_LED, `MFP_N_LED (16): LED bank width.
- N_PAT, 8: pattern table depth (power of 2, max 8).
- PRE_W, 24: prescaler/PERIOD width.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  reset
- HADDR  in  4  word register index
- HTRANS  in  2  AHB transfer type
- HWDATA  in  32  write data (data phase)
- HWRITE  in  1  write strobe (address phase)
- HSEL  in  1  slave select
- HRDATA  out  32  registered read data
- IO_LED  out  N_LED  LED drive, registered
- SEQ_DONE  out  1  one-shot sequence finished, level

Interface clocking and reset: reset HRESETn, asynchronous, active-low; clock HCLK.

Behaviour:

Register map (HADDR index):
- 0 CTRL: b0 EN, b1 ONESHOT.
- 1 PERIOD: PRE_W bits.
- 2 LENGTH: 3 bits, holds count-1.
- 3 MANUAL: N_LED bits.
- 4 STATUS: read-only; b1:0 state, b6:4 idx.
- 8..15 PATTERN[0..7]: N_LED bits.
- Other indices read 0; writes to them are ignored.

Bus timing:
- HADDR/HWRITE/HSEL/HTRANS are registered one cycle to align with HWDATA.
- we = HSEL_d & HWRITE_d & (HTRANS_d != IDLE).
- Register updates occur at the clock edge ending the data phase (edge E).
- Read: HRDATA is registered from the address-phase HADDR, and is valid the following cycle.
- Readback returns zero-extended register contents.

Reset values:
- All registers 0, so PERIOD=0 and LENGTH=0.
- State IDLE, idx 0, counter 0.
- IO_LED 0, HRDATA 0, SEQ_DONE 0.

FSM (IDLE=0, RUN=1, DONE=2):
- IDLE: a write of CTRL with EN=1 at edge E moves to RUN, sets idx←0 and cnt←max(PERIOD,1)-1. The PERIOD value used is the one held before E.
- RUN: if cnt≠0, cnt decrements.
  - If cnt==0 and idx<LENGTH: idx++ and cnt reloads.
  - If cnt==0 and idx≥LENGTH, with ONESHOT=0: idx←0 and cnt reloads.
  - If cnt==0 and idx≥LENGTH, with ONESHOT=1: go to DONE, idx holds.
- DONE: idx and IO_LED hold; SEQ_DONE=1.
- Any state: a CTRL write with EN=0 moves to IDLE at E, sets idx←0, and clears SEQ_DONE.
- A CTRL write with EN=1 while in RUN or DONE restarts the sequence (idx←0, cnt reload, SEQ_DONE cleared).

Output:
- IO_LED is registered from the current state.
  - IDLE → MANUAL.
  - RUN/DONE → PATTERN[idx].
- One cycle of latency after a state, idx or register change.
- Each index is displayed for exactly max(PERIOD,1) cycles.

Boundaries:
- PERIOD=0 behaves as 1, so the sequence advances every cycle.
- A PERIOD write mid-run takes effect at the next reload.
- A LENGTH write mid-run with idx>new LENGTH causes a wrap (or DONE) at the next step; idx is never out of range.
- A PATTERN write to the currently displayed idx shows on IO_LED 1 cycle after E.
- A MANUAL write while in RUN does not affect IO_LED.
- Async reset mid-run forces all reset values immediately.
- Read and write to the same register in consecutive cycles: the read returns the value before E only if the read address phase precedes E.

Decomposition:
- Register index constants H_LSEQ_CTRL/PERIOD/LENGTH/MANUAL/STATUS/PAT0 and FSM state encodings go in mfp_ahb_const.vh.
- One sub-module, mfp_led_seq_tick: prescaler with load/enable inputs and a tick output at cnt==0.
- Pattern table is a flop array in the top module.

Test Plan:
1. Reset, then read all registers → every readback 0; IO_LED=0.
2. Write MANUAL=16'hA5A5 → IO_LED=A5A5 two cycles after the address phase; STATUS state=0.
3. Write PATTERN[0..3]=1,2,4,8; PERIOD=3; LENGTH=3; CTRL=1 → IO_LED sequence 1,2,4,8,1,..., each value held exactly 3 cycles; SEQ_DONE stays 0.
4. Same setup with CTRL=3 (one-shot) → IO_LED goes 1,2,4,8 then holds at 8; SEQ_DONE=1 from the cycle the FSM enters DONE; STATUS=0x32.
5. While looping, write PERIOD=0, then CTRL=0 mid-step → IO_LED advances every cycle after the next reload; after the EN=0 write, IO_LED shows MANUAL one cycle later; idx=0.
6. Assert HRESETn low during RUN → IO_LED=0, SEQ_DONE=0 and state IDLE asynchronously; after release, a read of PATTERN[1] returns 0.

Source files
------------

// File: rtl/mfp_ahb_led_sequencer_pkg.sv
// Shared constants, register indices and state encoding for the AHB LED sequencer.
package mfp_ahb_led_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

  localparam logic [3:0] H_LSEQ_CTRL   = 4'd0;
  localparam logic [3:0] H_LSEQ_PERIOD = 4'd1;
  localparam logic [3:0] H_LSEQ_LENGTH = 4'd2;
  localparam logic [3:0] H_LSEQ_MANUAL = 4'd3;
  localparam logic [3:0] H_LSEQ_STATUS = 4'd4;
  localparam logic [3:0] H_LSEQ_PAT0   = 4'd8;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  function automatic logic [31:0] status_word(input seq_state_t s, input logic [2:0] idx);
    return {25'd0, idx, 2'b00, s};
  endfunction

endpackage

// File: rtl/mfp_ahb_led_sequencer_if.sv
// AHB-Lite slave-side bus bundle for the LED sequencer.
interface mfp_ahb_led_sequencer_if;
  logic [3:0]  HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HRDATA;

  modport master (output HADDR, HTRANS, HWDATA, HWRITE, HSEL, input HRDATA);
  modport slave  (input HADDR, HTRANS, HWDATA, HWRITE, HSEL, output HRDATA);
endinterface

// File: rtl/mfp_ahb_led_sequencer_tick.sv
// Step prescaler: loads max(period,1)-1, counts down while enabled, flags tick at zero.
module mfp_led_seq_tick #(
  parameter int PRE_W = 24
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             en,
  input  logic [PRE_W-1:0] period,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (period == '0) ? '0 : period - PRE_W'(1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - PRE_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/mfp_ahb_led_sequencer.sv
// AHB-Lite LED owner: shows a CPU-written value or steps through a pattern table.
module mfp_ahb_led_sequencer
  import mfp_ahb_led_sequencer_pkg::*;
#(
  parameter int N_LED = 16,
  parameter int N_PAT = 8,
  parameter int PRE_W = 24
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  mfp_ahb_led_sequencer_if.slave bus,
  output logic [N_LED-1:0]     IO_LED,
  output logic                 SEQ_DONE
);

  localparam int PAT_AW = $clog2(N_PAT);
  localparam logic [3:0] N_PAT4 = 4'(N_PAT);

  logic [3:0]       addr_d;
  logic [1:0]       trans_d;
  logic             write_d, sel_d;
  logic             we, ctrl_wr, rd_en;
  logic             ctrl_en, ctrl_oneshot;
  logic [PRE_W-1:0] period;
  logic [2:0]       length;
  logic [N_LED-1:0] manual;
  logic [N_LED-1:0] pattern [N_PAT];
  seq_state_t       state;
  logic [2:0]       idx;
  logic             tick, tick_load, tick_en, step_end;
  logic [31:0]      rdata_next;
  logic             unused_hwdata;

  assign unused_hwdata = ^bus.HWDATA;

  // Address phase is held one cycle so it lines up with HWDATA.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_d  <= '0;
      trans_d <= HTRANS_IDLE;
      write_d <= 1'b0;
      sel_d   <= 1'b0;
    end else begin
      addr_d  <= bus.HADDR;
      trans_d <= bus.HTRANS;
      write_d <= bus.HWRITE;
      sel_d   <= bus.HSEL;
    end
  end

  assign we      = sel_d & write_d & (trans_d != HTRANS_IDLE);
  assign ctrl_wr = we & (addr_d == H_LSEQ_CTRL);
  assign rd_en   = bus.HSEL & ~bus.HWRITE & (bus.HTRANS != HTRANS_IDLE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_en      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      period       <= '0;
      length       <= '0;
      manual       <= '0;
      for (int i = 0; i < N_PAT; i++) pattern[i] <= '0;
    end else if (we) begin
      case (addr_d)
        H_LSEQ_CTRL:   {ctrl_oneshot, ctrl_en} <= bus.HWDATA[1:0];
        H_LSEQ_PERIOD: period <= bus.HWDATA[PRE_W-1:0];
        H_LSEQ_LENGTH: length <= bus.HWDATA[2:0];
        H_LSEQ_MANUAL: manual <= bus.HWDATA[N_LED-1:0];
        default: begin
          if (addr_d[3] && ({1'b0, addr_d[2:0]} < N_PAT4))
            pattern[addr_d[PAT_AW-1:0]] <= bus.HWDATA[N_LED-1:0];
        end
      endcase
    end
  end

  always_comb begin
    rdata_next = '0;
    case (bus.HADDR)
      H_LSEQ_CTRL:   rdata_next = {30'd0, ctrl_oneshot, ctrl_en};
      H_LSEQ_PERIOD: rdata_next = 32'(period);
      H_LSEQ_LENGTH: rdata_next = {29'd0, length};
      H_LSEQ_MANUAL: rdata_next = 32'(manual);
      H_LSEQ_STATUS: rdata_next = status_word(state, idx);
      default: begin
        if (bus.HADDR[3] && ({1'b0, bus.HADDR[2:0]} < N_PAT4))
          rdata_next = 32'(pattern[bus.HADDR[PAT_AW-1:0]]);
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) bus.HRDATA <= '0;
    else if (rd_en) bus.HRDATA <= rdata_next;
  end

  assign step_end  = (idx >= length);
  assign tick_en   = (state == S_RUN);
  // The prescaler reloads on start/restart and on every step that does not finish a one-shot.
  assign tick_load = (ctrl_wr & bus.HWDATA[0]) |
                     (tick_en & tick & ~(step_end & ctrl_oneshot));

  mfp_led_seq_tick #(.PRE_W(PRE_W)) u_tick (
    .clk    (HCLK),
    .resetn (HRESETn),
    .load   (tick_load),
    .en     (tick_en),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      idx      <= '0;
      SEQ_DONE <= 1'b0;
    end else if (ctrl_wr) begin
      state    <= bus.HWDATA[0] ? S_RUN : S_IDLE;
      idx      <= '0;
      SEQ_DONE <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (tick) begin
            if (!step_end) begin
              idx <= idx + 3'd1;
            end else if (!ctrl_oneshot) begin
              idx <= '0;
            end else begin
              state    <= S_DONE;
              SEQ_DONE <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) IO_LED <= '0;
    else IO_LED <= (state == S_IDLE) ? manual : pattern[idx[PAT_AW-1:0]];
  end

endmodule

// File: tb/tb_mfp_ahb_led_sequencer.sv
// Self-checking bench: register table vectors, directed sequences and randomized runs vs an index-arithmetic model.
module tb_mfp_ahb_led_sequencer;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [15:0] IO_LED;
  logic        SEQ_DONE;

  mfp_ahb_led_sequencer_if bus();

  mfp_ahb_led_sequencer #(.N_LED(16), .N_PAT(8), .PRE_W(24)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .bus      (bus),
    .IO_LED   (IO_LED),
    .SEQ_DONE (SEQ_DONE)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] pat [8];
  logic [15:0] manual_m;
  vec_t        vecs [19];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HWRITE = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = a;
    @(posedge HCLK); #1;
    bus.HWDATA = d; bus.HSEL = 1'b0; bus.HWRITE = 1'b0; bus.HTRANS = 2'b00;
    if (a[3]) pat[a[2:0]] = d[15:0];
    if (a == 4'd3) manual_m = d[15:0];
  endtask

  task automatic busRead(input logic [3:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HWRITE = 1'b0; bus.HTRANS = 2'b10; bus.HADDR = a;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    d = bus.HRDATA;
  endtask

  task automatic applyStimulus(input vec_t v, input int i);
    logic [31:0] rd;
    if (v.wr) begin
      busWrite(v.addr, v.data);
    end else begin
      busRead(v.addr, rd);
      checkOutput($sformatf("vec%0d_rd%0d", i, v.addr), rd, v.exp);
    end
  endtask

  // Display index k cycles after start is k/P, wrapping modulo LENGTH+1 or clamping in one-shot.
  task automatic runSequence(input int per, input int len, input bit oneshot, input int ncyc);
    int pe, k;
    logic [15:0] e;
    pe = (per == 0) ? 1 : per;
    busWrite(4'd0, {30'd0, oneshot, 1'b1});
    @(posedge HCLK);
    for (int j = 0; j < ncyc; j++) begin
      @(posedge HCLK); #1;
      k = j / pe;
      e = oneshot ? pat[(k > len) ? len : k] : pat[k % (len + 1)];
      checkOutput($sformatf("seq_led p%0d l%0d o%0d j%0d", per, len, oneshot, j), 32'(IO_LED), 32'(e));
      checkOutput($sformatf("seq_done p%0d l%0d o%0d j%0d", per, len, oneshot, j),
                  32'(SEQ_DONE), 32'(oneshot && (j + 1 >= (len + 1) * pe)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [15:0] prev, e;
    int len, per, os, pe;

    vecs[0]  = '{1'b0, 4'd0,  32'h0,        32'h0};
    vecs[1]  = '{1'b0, 4'd1,  32'h0,        32'h0};
    vecs[2]  = '{1'b0, 4'd2,  32'h0,        32'h0};
    vecs[3]  = '{1'b0, 4'd3,  32'h0,        32'h0};
    vecs[4]  = '{1'b0, 4'd4,  32'h0,        32'h0};
    vecs[5]  = '{1'b0, 4'd8,  32'h0,        32'h0};
    vecs[6]  = '{1'b0, 4'd15, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 4'd1,  32'hFFFFFFFF, 32'h0};
    vecs[8]  = '{1'b0, 4'd1,  32'h0,        32'h00FFFFFF};
    vecs[9]  = '{1'b1, 4'd2,  32'hFFFFFFFD, 32'h0};
    vecs[10] = '{1'b0, 4'd2,  32'h0,        32'h5};
    vecs[11] = '{1'b1, 4'd3,  32'h1234ABCD, 32'h0};
    vecs[12] = '{1'b0, 4'd3,  32'h0,        32'hABCD};
    vecs[13] = '{1'b1, 4'd0,  32'hFFFFFFFE, 32'h0};
    vecs[14] = '{1'b0, 4'd0,  32'h0,        32'h2};
    vecs[15] = '{1'b1, 4'd5,  32'hDEADBEEF, 32'h0};
    vecs[16] = '{1'b0, 4'd5,  32'h0,        32'h0};
    vecs[17] = '{1'b1, 4'd15, 32'hFFFF5A5A, 32'h0};
    vecs[18] = '{1'b0, 4'd15, 32'h0,        32'h5A5A};

    for (int i = 0; i < 8; i++) pat[i] = '0;
    manual_m = '0;
    bus.HSEL = 1'b0; bus.HWRITE = 1'b0; bus.HTRANS = 2'b00; bus.HADDR = '0; bus.HWDATA = '0;
    HRESETn = 1'b0;
    #22 HRESETn = 1'b1;

    checkOutput("reset_led", 32'(IO_LED), 32'h0);
    checkOutput("reset_done", 32'(SEQ_DONE), 32'h0);
    checkOutput("reset_hrdata", bus.HRDATA, 32'h0);

    for (int i = 0; i < 19; i++) applyStimulus(vecs[i], i);
    busRead(4'd12, rd);
    checkOutput("unwritten_pat4", rd, 32'h0);

    prev = manual_m;
    busWrite(4'd3, 32'h0000A5A5);
    @(posedge HCLK); #1;
    checkOutput("manual_latency_old", 32'(IO_LED), 32'(prev));
    @(posedge HCLK); #1;
    checkOutput("manual_latency_new", 32'(IO_LED), 32'hA5A5);
    busRead(4'd4, rd);
    checkOutput("status_idle", rd, 32'h0);

    busWrite(4'd8, 32'h1);
    busWrite(4'd9, 32'h2);
    busWrite(4'd10, 32'h4);
    busWrite(4'd11, 32'h8);
    busWrite(4'd1, 32'd3);
    busWrite(4'd2, 32'd3);
    runSequence(3, 3, 1'b0, 16);

    runSequence(3, 3, 1'b1, 16);
    busRead(4'd4, rd);
    checkOutput("status_done", rd, 32'h32);
    busWrite(4'd3, 32'h1111);
    @(posedge HCLK);
    @(posedge HCLK); #1;
    checkOutput("manual_in_done", 32'(IO_LED), 32'h8);
    busWrite(4'd11, 32'h0077);
    @(posedge HCLK);
    @(posedge HCLK); #1;
    checkOutput("pat_live_update", 32'(IO_LED), 32'h77);
    checkOutput("done_held", 32'(SEQ_DONE), 32'h1);

    busWrite(4'd11, 32'h8);
    runSequence(3, 3, 1'b0, 6);
    busWrite(4'd1, 32'd0);
    repeat (6) @(posedge HCLK);
    #1 prev = IO_LED;
    for (int i = 0; i < 6; i++) begin
      @(posedge HCLK); #1;
      e = (prev == 16'h8) ? 16'h1 : 16'(prev << 1);
      checkOutput($sformatf("period0_step%0d", i), 32'(IO_LED), 32'(e));
      prev = e;
    end
    busWrite(4'd0, 32'h0);
    @(posedge HCLK);
    @(posedge HCLK); #1;
    checkOutput("disable_shows_manual", 32'(IO_LED), 32'(manual_m));
    busRead(4'd4, rd);
    checkOutput("status_after_disable", rd, 32'h0);
    checkOutput("done_after_disable", 32'(SEQ_DONE), 32'h0);

    // Read address phase overlapping the write data phase sees the old value.
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HWRITE = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 4'd1;
    @(posedge HCLK); #1;
    bus.HWDATA = 32'd7; bus.HWRITE = 1'b0; bus.HADDR = 4'd1;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    checkOutput("raw_old_value", bus.HRDATA, 32'h0);
    busRead(4'd1, rd);
    checkOutput("raw_new_value", rd, 32'd7);

    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(0, 7);
      per = $urandom_range(0, 4);
      os  = $urandom_range(0, 1);
      pe  = (per == 0) ? 1 : per;
      for (int i = 0; i < 8; i++) busWrite(4'(8 + i), $urandom);
      busWrite(4'd1, 32'(per));
      busWrite(4'd2, 32'(len));
      runSequence(per, len, os[0], (len + 1) * pe + 3);
    end

    busWrite(4'd8, 32'h1);
    busWrite(4'd9, 32'h2);
    busWrite(4'd1, 32'd2);
    busWrite(4'd2, 32'd1);
    runSequence(2, 1, 1'b1, 8);
    #2 HRESETn = 1'b0;
    #1;
    checkOutput("async_reset_led", 32'(IO_LED), 32'h0);
    checkOutput("async_reset_done", 32'(SEQ_DONE), 32'h0);
    #20 HRESETn = 1'b1;
    busRead(4'd9, rd);
    checkOutput("post_reset_pat1", rd, 32'h0);
    busRead(4'd4, rd);
    checkOutput("post_reset_status", rd, 32'h0);
    checkOutput("post_reset_led", 32'(IO_LED), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
